// File: rtl/noc_params.sv
// Shared NoC router definitions: flit labels, head-flit fields and the flit format
// carried through the per-VC input buffers.
package noc_params;

   typedef enum logic [1:0] {
      HEAD     = 2'd0,
      BODY     = 2'd1,
      TAIL     = 2'd2,
      HEADTAIL = 2'd3
   } flit_label_t;

   localparam int VC_SIZE           = 2;
   localparam int DEST_ADDR_SIZE    = 4;
   localparam int HEAD_PAYLOAD_SIZE = 16;
   // Body/tail payload spans the whole head-data footprint so the union members line up.
   localparam int FLIT_DATA_SIZE    = VC_SIZE + 2 * DEST_ADDR_SIZE + HEAD_PAYLOAD_SIZE;

   typedef struct packed {
      logic [VC_SIZE-1:0]           vc_id;
      logic [DEST_ADDR_SIZE-1:0]    x_dest;
      logic [DEST_ADDR_SIZE-1:0]    y_dest;
      logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
   } head_data_t;

   typedef union packed {
      head_data_t                head_data;
      logic [FLIT_DATA_SIZE-1:0] bt_pl;
   } flit_data_t;

   typedef struct packed {
      flit_label_t flit_label;
      flit_data_t  data;
   } flit_t;

endpackage

// File: rtl/circular_buffer.sv
// Per-VC flit FIFO built as a circular buffer with a combinational head output.
// Define CIRCULAR_BUFFER_ERR_EN to add registered overflow_o/underflow_o pulses.
module circular_buffer
   import noc_params::*;
#(
   parameter int BUFFER_SIZE = 8
) (
   input  logic  clk,
   input  logic  rst,
   input  flit_t data_i,
   input  logic  read_i,
   input  logic  write_i,
   output flit_t data_o,
   output logic  is_full_o,
   output logic  is_empty_o
`ifdef CIRCULAR_BUFFER_ERR_EN
   ,
   output logic  overflow_o,
   output logic  underflow_o
`endif
);

   localparam int PTR_W = $clog2(BUFFER_SIZE);
   localparam int CNT_W = $clog2(BUFFER_SIZE + 1);

   flit_t            r_mem [BUFFER_SIZE];
   logic [PTR_W-1:0] r_read_ptr;
   logic [PTR_W-1:0] r_write_ptr;
   logic [CNT_W-1:0] r_num_flits;

   logic w_wr_en;
   logic w_rd_en;

   // Explicit wrap so a non-power-of-two depth never indexes past the last entry.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(BUFFER_SIZE - 1))
         return '0;
      return ptr + PTR_W'(1);
   endfunction

   assign is_empty_o = (r_num_flits == '0);
   assign is_full_o  = (r_num_flits == CNT_W'(BUFFER_SIZE));

   assign w_wr_en = write_i & (~is_full_o | read_i);
   assign w_rd_en = read_i & ~is_empty_o;

   assign data_o = r_mem[r_read_ptr];

   // NOTE: storage has no reset; the count alone defines which entries are valid.
   always_ff @(posedge clk) begin
      if (w_wr_en)
         r_mem[r_write_ptr] <= data_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_read_ptr  <= '0;
         r_write_ptr <= '0;
         r_num_flits <= '0;
      end else begin
         if (w_wr_en)
            r_write_ptr <= next_ptr(r_write_ptr);
         if (w_rd_en)
            r_read_ptr <= next_ptr(r_read_ptr);
         case ({w_wr_en, w_rd_en})
            2'b10:   r_num_flits <= r_num_flits + CNT_W'(1);
            2'b01:   r_num_flits <= r_num_flits - CNT_W'(1);
            default: r_num_flits <= r_num_flits;
         endcase
      end
   end

`ifdef CIRCULAR_BUFFER_ERR_EN
   logic r_overflow;
   logic r_underflow;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= write_i & is_full_o & ~read_i;
         r_underflow <= read_i & is_empty_o;
      end
   end

   assign overflow_o  = r_overflow;
   assign underflow_o = r_underflow;
`endif

endmodule

// File: tb/tb_circular_buffer.sv
// Directed self-checking bench for circular_buffer (default build, depth 8).
module tb_circular_buffer;
   import noc_params::*;

   localparam int DEPTH = 8;

   logic  clk;
   logic  rst;
   flit_t data_i;
   logic  read_i;
   logic  write_i;
   flit_t data_o;
   logic  is_full_o;
   logic  is_empty_o;

   int tests_run;
   int tests_failed;

   circular_buffer #(.BUFFER_SIZE(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_i     (data_i),
      .read_i     (read_i),
      .write_i    (write_i),
      .data_o     (data_o),
      .is_full_o  (is_full_o),
      .is_empty_o (is_empty_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flit i: HEAD label, every field filled with i.
   function automatic flit_t mk_flit(input int i);
      flit_t      f;
      logic [7:0] b;
      b = i[7:0];
      f.flit_label             = HEAD;
      f.data.head_data.vc_id   = b[1:0];
      f.data.head_data.x_dest  = b[3:0];
      f.data.head_data.y_dest  = b[3:0];
      f.data.head_data.head_pl = {b, b};
      return f;
   endfunction

   task automatic check_bit(input string tag, input logic observed, input logic expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   task automatic check_flit(input string tag, input flit_t observed, input flit_t expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      flit_t flit_x;
      tests_run    = 0;
      tests_failed = 0;
      flit_x       = '0;
      flit_x.flit_label = BODY;
      flit_x.data.bt_pl = '1;

      rst     = 1'b0;
      read_i  = 1'b0;
      write_i = 1'b0;
      data_i  = '0;
      repeat (5) tick();
      check_bit("reset_empty", is_empty_o, 1'b1);
      check_bit("reset_full", is_full_o, 1'b0);
      rst = 1'b1;
      tick();
      check_bit("idle_empty", is_empty_o, 1'b1);
      check_bit("idle_full", is_full_o, 1'b0);

      // Fill with flits 0..7.
      write_i = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         data_i = mk_flit(i);
         tick();
         check_bit($sformatf("fill_empty_%0d", i), is_empty_o, 1'b0);
         check_bit($sformatf("fill_full_%0d", i), is_full_o, (i == DEPTH - 1));
         check_flit($sformatf("fill_head_%0d", i), data_o, mk_flit(0));
      end

      // Write while full without read: ignored.
      data_i = flit_x;
      tick();
      check_bit("wfull_full", is_full_o, 1'b1);
      check_flit("wfull_head", data_o, mk_flit(0));

      // Read and write while full: stays full, head advances.
      read_i = 1'b1;
      data_i = mk_flit(8);
      tick();
      check_bit("rwfull_full", is_full_o, 1'b1);
      check_flit("rwfull_head", data_o, mk_flit(1));

      // Drain: flits 1..7 then 8; flit_x must never show up.
      write_i = 1'b0;
      data_i  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         check_flit($sformatf("drain_head_%0d", k), data_o, mk_flit(k + 1));
         tick();
      end
      check_bit("drain_empty", is_empty_o, 1'b1);
      check_bit("drain_full", is_full_o, 1'b0);

      // Reads while empty are ignored.
      tick();
      tick();
      check_bit("rempty_empty", is_empty_o, 1'b1);
      check_bit("rempty_full", is_full_o, 1'b0);

      // Write 5 (pointers 1..5); first head proves the empty reads moved nothing.
      read_i  = 1'b0;
      write_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         data_i = mk_flit(20 + i);
         tick();
      end
      write_i = 1'b0;
      read_i  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check_flit($sformatf("pre_wrap_head_%0d", k), data_o, mk_flit(20 + k));
         tick();
      end
      check_bit("pre_wrap_empty", is_empty_o, 1'b1);

      // Pointers now at 6: three flits occupy slots 6, 7, 0.
      read_i  = 1'b0;
      write_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         data_i = mk_flit(30 + i);
         tick();
      end
      // Simultaneous read/write while partially full: count holds.
      read_i = 1'b1;
      data_i = mk_flit(33);
      tick();
      check_flit("partial_rw_head", data_o, mk_flit(31));
      check_bit("partial_rw_empty", is_empty_o, 1'b0);
      write_i = 1'b0;
      for (int k = 1; k < 4; k++) begin
         check_flit($sformatf("wrap_head_%0d", k), data_o, mk_flit(30 + k));
         tick();
      end
      check_bit("wrap_empty", is_empty_o, 1'b1);

      // Read and write while empty: write only, no bypass.
      write_i = 1'b1;
      data_i  = mk_flit(40);
      tick();
      check_bit("rwempty_empty", is_empty_o, 1'b0);
      check_flit("rwempty_head", data_o, mk_flit(40));
      write_i = 1'b0;
      tick();
      check_bit("rwempty_drain", is_empty_o, 1'b1);

      // Asynchronous reset mid-operation discards contents.
      read_i  = 1'b0;
      write_i = 1'b1;
      data_i  = mk_flit(50);
      tick();
      tick();
      write_i = 1'b0;
      check_bit("pre_rst_empty", is_empty_o, 1'b0);
      #2 rst = 1'b0;
      #1;
      check_bit("async_rst_empty", is_empty_o, 1'b1);
      check_bit("async_rst_full", is_full_o, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      check_bit("post_rst_empty", is_empty_o, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
